// File: rtl/intc_pkg.sv
// intc_pkg: shared constants for the intc_sopc interrupt controller.
//   - register word offsets (byte address bits [5:2])
//   - ROUTE field width and the legal parameter ceilings
package intc_pkg;

  localparam int unsigned MAX_SRC       = 32;
  localparam int unsigned MAX_OUT       = 8;
  localparam int unsigned ROUTE_FIELD_W = 4;

  localparam int unsigned OFF_RAW      = 0;
  localparam int unsigned OFF_PENDING  = 1;
  localparam int unsigned OFF_ENABLE   = 2;
  localparam int unsigned OFF_MODE     = 3;
  localparam int unsigned OFF_POLARITY = 4;
  localparam int unsigned OFF_VECTOR   = 5;
  localparam int unsigned OFF_ROUTE0   = 8;
  localparam int unsigned OFF_ROUTE1   = 9;
  localparam int unsigned OFF_ROUTE2   = 10;
  localparam int unsigned OFF_ROUTE3   = 11;

endpackage

// File: rtl/intc_sopc_if.sv
// intc_sopc_if: data-RAM-style register bus used to reach the interrupt
// controller.
//   ce     : block select
//   we     : 1 = write, 0 = read
//   sel    : byte enables, sel[i] gates data_i[8i+7:8i]
//   addr   : byte address
//   data_i : write data
//   data_o : read data (combinational from the slave)
interface intc_sopc_if;
  logic        ce;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, sel, addr, data_i, input data_o);
  modport slave  (input ce, we, sel, addr, data_i, output data_o);
endinterface

// File: rtl/intc_src.sv
// intc_src: one interrupt source slice.
//   clk, reset_n : clock, asynchronous active-low reset
//   irq          : raw source input
//   polarity     : 1 = source is active-low
//   mode         : 1 = edge, 0 = level
//   clr          : write-1-to-clear strobe for this bit (edge mode only)
//   lvl          : polarity-corrected (and optionally synchronized) level
//   pending      : pending flag
// Build option INTC_SYNC_EN: adds a 2-flop synchronizer ahead of the
// polarity XOR.
module intc_src
  import intc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic irq,
  input  logic polarity,
  input  logic mode,
  input  logic clr,
  output logic lvl,
  output logic pending
);

  logic irq_s;
  logic prev;

`ifdef INTC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], irq};
  end

  assign irq_s = sync[1];
`else
  assign irq_s = irq;
`endif

  assign lvl = irq_s ^ polarity;

  // Edge history runs in both modes so a level->edge switch with the
  // source already active does not fabricate a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= lvl;
      if (mode) pending <= (lvl & ~prev) | (pending & ~clr);
      else      pending <= lvl;
    end
  end

endmodule

// File: rtl/intc_sopc.sv
// intc_sopc: parametrised interrupt controller for the minimal SOPC.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   irq_i   : NUM_SRC raw interrupt sources (bit 0 = timer)
//   bus     : register bus slave (ce/we/sel/addr/data_i/data_o)
//   int_o   : NUM_OUT registered interrupt lines to the CPU int_i
// Registers (word offset addr[5:2]): 0 RAW, 1 PENDING (W1C), 2 ENABLE,
// 3 MODE, 4 POLARITY, 5 VECTOR, 8..11 ROUTE0..3 (4-bit field per source).
// Build option INTC_SYNC_EN: per-source 2-flop input synchronizers.
module intc_sopc
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned NUM_OUT = 6,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_i,
  intc_sopc_if.slave         bus,
  output logic [NUM_OUT-1:0] int_o
);

  if (NUM_SRC < 1 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("intc_sopc: NUM_SRC out of range 1..32");
  end
  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("intc_sopc: NUM_OUT out of range 1..8");
  end

  logic [31:0]                       word;
  logic                              wr;
  logic                              unused_addr;
  logic [NUM_SRC-1:0]                wm, wd;
  logic [NUM_SRC-1:0]                en, mode, pol, lvl, pend, clr, act;
  logic [ROUTE_FIELD_W*MAX_SRC-1:0]  route_flat;
  logic [NUM_OUT*NUM_SRC-1:0]        line_hit;
  logic [NUM_OUT-1:0]                int_nxt;
  logic                              vec_any;
  logic [7:0]                        vec_idx;
  logic                              vec_found;

  assign word        = 32'(bus.addr[ADDR_W-1:2]);
  assign unused_addr = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};
  assign wr          = bus.ce & bus.we;
  assign wd          = bus.data_i[NUM_SRC-1:0];
  assign clr         = (wr && word == OFF_PENDING) ? (wd & wm) : '0;
  assign act         = pend & en;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    localparam int unsigned RT_WORD = OFF_ROUTE0 + s / 8;
    localparam int unsigned RT_LSB  = ROUTE_FIELD_W * (s % 8);
    localparam int unsigned RT_BYTE = (s % 8) / 2;

    logic [ROUTE_FIELD_W-1:0] route;

    assign wm[s] = bus.sel[s / 8];

    intc_src u_src (
      .clk      (clk),
      .reset_n  (reset_n),
      .irq      (irq_i[s]),
      .polarity (pol[s]),
      .mode     (mode[s]),
      .clr      (clr[s]),
      .lvl      (lvl[s]),
      .pending  (pend[s])
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) route <= '0;
      else if (wr && word == RT_WORD && bus.sel[RT_BYTE])
        route <= bus.data_i[RT_LSB +: ROUTE_FIELD_W];
    end

    assign route_flat[ROUTE_FIELD_W*s +: ROUTE_FIELD_W] = route;
  end

  if (NUM_SRC < MAX_SRC) begin : g_route_pad
    assign route_flat[ROUTE_FIELD_W*MAX_SRC-1:ROUTE_FIELD_W*NUM_SRC] = '0;
  end

  // Out-of-range ROUTE values never match any k, so they stay unrouted.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_line
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_hit
      assign line_hit[k*NUM_SRC + s] = act[s] &&
        (route_flat[ROUTE_FIELD_W*s +: ROUTE_FIELD_W] == ROUTE_FIELD_W'(k));
    end
    assign int_nxt[k] = |line_hit[k*NUM_SRC +: NUM_SRC];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en    <= '0;
      mode  <= '0;
      pol   <= '0;
      int_o <= '0;
    end else begin
      int_o <= int_nxt;
      if (wr) begin
        case (word)
          OFF_ENABLE:   en   <= (en   & ~wm) | (wd & wm);
          OFF_MODE:     mode <= (mode & ~wm) | (wd & wm);
          OFF_POLARITY: pol  <= (pol  & ~wm) | (wd & wm);
          default: ;
        endcase
      end
    end
  end

  assign vec_any = |act;

  always_comb begin
    vec_idx   = '0;
    vec_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (act[i] && !vec_found) begin
        vec_idx   = 8'(i);
        vec_found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (bus.ce && !bus.we) begin
      case (word)
        OFF_RAW:      bus.data_o = 32'(lvl);
        OFF_PENDING:  bus.data_o = 32'(pend);
        OFF_ENABLE:   bus.data_o = 32'(en);
        OFF_MODE:     bus.data_o = 32'(mode);
        OFF_POLARITY: bus.data_o = 32'(pol);
        OFF_VECTOR:   bus.data_o = {vec_any, 23'b0, vec_idx};
        OFF_ROUTE0:   bus.data_o = route_flat[31:0];
        OFF_ROUTE1:   bus.data_o = route_flat[63:32];
        OFF_ROUTE2:   bus.data_o = route_flat[95:64];
        OFF_ROUTE3:   bus.data_o = route_flat[127:96];
        default:      bus.data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_sopc.sv
// tb_intc_sopc: self-checking bench for intc_sopc (NUM_SRC=8, NUM_OUT=6).
// Table-driven register vectors, hand-written latency/priority sequences,
// and randomized traffic checked against a behavioural model.
module tb_intc_sopc;

  localparam int unsigned NSRC = 8;
  localparam int unsigned NOUT = 6;
`ifdef INTC_SYNC_EN
  localparam int unsigned SD = 2;
`else
  localparam int unsigned SD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq;
  logic [5:0]  int_o;

  intc_sopc_if bus ();

  intc_sopc #(.NUM_SRC(NSRC), .NUM_OUT(NOUT), .ADDR_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_i   (irq),
    .bus     (bus),
    .int_o   (int_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  logic [7:0] m_en, m_mode, m_pol, m_pend, m_prev;
  logic [3:0] m_route [8];
  logic [5:0] m_int;
  logic [7:0] m_q [$];

  function automatic logic [7:0] m_lvl();
    logic [7:0] e;
    if (SD == 0) e = irq;
    else         e = m_q[0];
    return e ^ m_pol;
  endfunction

  task automatic m_reset();
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0; m_int = '0;
    for (int s = 0; s < 8; s++) m_route[s] = '0;
    m_q.delete();
    for (int i = 0; i < int'(SD); i++) m_q.push_back(8'h00);
  endtask

  task automatic m_step();
    logic [7:0] lvl, wm;
    logic [5:0] nint;
    logic [3:0] w;
    logic       wr, rise, clr;
    lvl  = m_lvl();
    nint = '0;
    for (int s = 0; s < 8; s++)
      if (m_pend[s] && m_en[s] && m_route[s] < NOUT) nint[m_route[s]] = 1'b1;
    wr = bus.ce && bus.we;
    w  = bus.addr[5:2];
    wm = {8{bus.sel[0]}};
    for (int s = 0; s < 8; s++) begin
      if (m_mode[s]) begin
        rise = lvl[s] && !m_prev[s];
        clr  = wr && w == 4'd1 && bus.data_i[s] && bus.sel[0];
        m_pend[s] = rise || (m_pend[s] && !clr);
      end else begin
        m_pend[s] = lvl[s];
      end
    end
    m_prev = lvl;
    if (SD > 0) begin
      m_q.push_back(irq);
      void'(m_q.pop_front());
    end
    if (wr) begin
      case (w)
        4'd2: m_en   = (m_en   & ~wm) | (bus.data_i[7:0] & wm);
        4'd3: m_mode = (m_mode & ~wm) | (bus.data_i[7:0] & wm);
        4'd4: m_pol  = (m_pol  & ~wm) | (bus.data_i[7:0] & wm);
        4'd8: for (int s = 0; s < 8; s++)
                if (bus.sel[s/2]) m_route[s] = bus.data_i[4*s +: 4];
        default: ;
      endcase
    end
    m_int = nint;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    case (a[5:2])
      4'd0: r = {24'b0, m_lvl()};
      4'd1: r = {24'b0, m_pend};
      4'd2: r = {24'b0, m_en};
      4'd3: r = {24'b0, m_mode};
      4'd4: r = {24'b0, m_pol};
      4'd5: for (int s = 7; s >= 0; s--)
              if (m_pend[s] && m_en[s]) r = {1'b1, 23'b0, 8'(s)};
      4'd8: for (int s = 0; s < 8; s++) r[4*s +: 4] = m_route[s];
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) m_reset();
    else          m_step();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.ce = 1'b0; bus.we = 1'b0; bus.sel = '0; bus.addr = '0; bus.data_i = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d; bus.sel = s;
    cyc();
    bus_idle();
  endtask

  task automatic rd_const(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 check(name, bus.data_o, exp);
    bus_idle();
  endtask

  task automatic rd_model(input string name, input logic [31:0] a);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 check(name, bus.data_o, m_read(a));
    bus_idle();
  endtask

  task automatic do_reset();
    irq = '0;
    bus_idle();
    reset_n = 1'b0;
    m_reset();
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] rnd_addrs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h08, 32'hFFFF_FFFF, 4'b0001, 32'h0000_00FF};
    tbl[1]  = '{32'h08, 32'h1234_5678, 4'b1111, 32'h0000_0078};
    tbl[2]  = '{32'h08, 32'hFFFF_FFFF, 4'b1110, 32'h0000_0078};
    tbl[3]  = '{32'h0C, 32'h0000_00A5, 4'b1111, 32'h0000_00A5};
    tbl[4]  = '{32'h10, 32'h0000_003C, 4'b1111, 32'h0000_003C};
    tbl[5]  = '{32'h00, 32'hFFFF_FFFF, 4'b1111, 32'h0000_003C};
    tbl[6]  = '{32'h20, 32'h1234_5678, 4'b1111, 32'h1234_5678};
    tbl[7]  = '{32'h20, 32'hFFFF_FFFF, 4'b0100, 32'h12FF_5678};
    tbl[8]  = '{32'h24, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    tbl[9]  = '{32'h30, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    tbl[10] = '{32'h18, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    rnd_addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h24, 32'h30, 32'h18};

    reset_n = 1'b0;
    irq     = '0;
    bus_idle();
    m_reset();
    @(negedge clk);

    // reset state
    check("rst_int_o", 32'(int_o), 32'h0);
    rd_const("rst_enable", 32'h08, 32'h0);
    rd_const("rst_pending", 32'h04, 32'h0);
    rd_const("rst_route0", 32'h20, 32'h0);
    rd_const("rst_vector", 32'h14, 32'h0);
    cyc();
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      wr(tbl[i].addr, tbl[i].wdata, tbl[i].sel);
      rd_const($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // level source 0 with enable off
    do_reset();
    irq = 8'h01;
    repeat (1 + SD) cyc();
    check("s1_int_o", 32'(int_o), 32'h0);
    rd_const("s1_pending", 32'h04, 32'h1);
    rd_const("s1_raw", 32'h00, 32'h1);
    cyc();
    check("s1_int_o_late", 32'(int_o), 32'h0);

    // edge source 0: latency, W1C, held level does not re-arm
    do_reset();
    wr(32'h08, 32'h1, 4'hF);
    wr(32'h0C, 32'h1, 4'hF);
    irq = 8'h01;
    repeat (1 + SD) cyc();
    check("s2_int_early", 32'(int_o), 32'h0);
    cyc();
    check("s2_int_on", 32'(int_o), 32'h1);
    wr(32'h04, 32'h1, 4'hF);
    check("s2_int_hold", 32'(int_o), 32'h1);
    cyc();
    check("s2_int_clr", 32'(int_o), 32'h0);
    repeat (3) cyc();
    check("s2_no_rearm", 32'(int_o), 32'h0);
    rd_const("s2_pending", 32'h04, 32'h0);

    // set beats simultaneous W1C
    do_reset();
    wr(32'h0C, 32'h08, 4'hF);
    irq = 8'h08;
    repeat (SD) cyc();
    wr(32'h04, 32'h08, 4'hF);
    rd_const("s3_set_wins", 32'h04, 32'h08);

    // routing and VECTOR
    do_reset();
    wr(32'h20, 32'h0000_5000, 4'hF);
    wr(32'h08, 32'h0C, 4'hF);
    irq = 8'h0C;
    repeat (1 + SD) cyc();
    rd_const("s4_vector", 32'h14, 32'h8000_0002);
    cyc();
    check("s4_int_two", 32'(int_o), 32'h21);
    wr(32'h20, 32'h0000_7000, 4'hF);
    check("s4_int_route_old", 32'(int_o), 32'h21);
    cyc();
    check("s4_int_unrouted", 32'(int_o), 32'h01);

    // async reset with int_o active, then reset during a write
    #2 reset_n = 1'b0;
    m_reset();
    #1 check("s6_async_int", 32'(int_o), 32'h0);
    rd_const("s6_async_route", 32'h20, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    irq = '0;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h08; bus.data_i = 32'hFF; bus.sel = 4'hF;
    #2 reset_n = 1'b0;
    m_reset();
    cyc();
    bus_idle();
    reset_n = 1'b1;
    rd_const("s6_write_lost", 32'h08, 32'h0);

    // polarity, byte write, unmapped offset
    do_reset();
    wr(32'h10, 32'h2, 4'hF);
    rd_const("s5_raw_pol", 32'h00, 32'h2);
    wr(32'h08, 32'hFFFF_FFFF, 4'b0001);
    rd_const("s5_enable_byte", 32'h08, 32'hFF);
    rd_const("s5_unmapped", 32'h30, 32'h0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int unsigned op, ai;
      irq = 8'($urandom);
      op  = $urandom_range(0, 9);
      ai  = $urandom_range(0, 9);
      if (op < 3) begin
        bus.ce = 1'b1; bus.we = 1'b1; bus.addr = rnd_addrs[ai];
        bus.data_i = $urandom; bus.sel = 4'($urandom_range(0, 15));
        #1 check("rnd_dout_wr", bus.data_o, 32'h0);
        cyc();
        bus_idle();
      end else if (op < 7) begin
        rd_model("rnd_read", rnd_addrs[ai]);
        cyc();
      end else begin
        #1 check("rnd_dout_idle", bus.data_o, 32'h0);
        cyc();
      end
      check("rnd_int_o", 32'(int_o), 32'(m_int));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
